// File: rtl/input_cpuid_requester.sv
// Requester side of the CPUID allocation handshake: pops a descriptor, requests a
// CPUID with a level req/ack exchange, then forwards the tagged descriptor or drops it.
module input_cpuid_requester #(
    parameter int DESC_W  = 64,
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        in_desc_key,
    input  logic [DESC_W-1:0] in_desc_data,
    input  logic              in_desc_empty,
    output logic              out_desc_rdreq,
    output logic              out_input_ctl,
    output logic [4:0]        out_input_key,
    input  logic              in_input_ack,
    input  logic              in_input_valid,
    input  logic [4:0]        in_input_cpuid,
    output logic              out_desc_valid,
    output logic [DESC_W-1:0] out_desc_data,
    output logic [4:0]        out_desc_cpuid,
    input  logic              in_desc_ready,
    output logic [31:0]       out_drop_cnt,
    output logic [31:0]       out_timeout_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state_q;
    logic [4:0]        key_q;
    logic [DESC_W-1:0] data_q;
    logic [TO_W-1:0]   timer_q;
    logic              grant_valid_q;
    logic [4:0]        grant_cpuid_q;
    logic              timed_out_q;
    logic              rdreq_q;
    logic              ctl_q;
    logic              out_valid_q;
    logic [DESC_W-1:0] out_data_q;
    logic [4:0]        out_cpuid_q;
    logic [31:0]       drop_cnt_q;
    logic [31:0]       to_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Handshake FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            key_q         <= 5'd0;
            data_q        <= '0;
            timer_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_cpuid_q <= 5'd0;
            timed_out_q   <= 1'b0;
            rdreq_q       <= 1'b0;
            ctl_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_cpuid_q   <= 5'd0;
            drop_cnt_q    <= 32'd0;
            to_cnt_q      <= 32'd0;
        end else begin
            rdreq_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!in_desc_empty) begin
                        key_q   <= in_desc_key;
                        data_q  <= in_desc_data;
                        rdreq_q <= 1'b1;
                        ctl_q   <= 1'b1;
                        timer_q <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // Ack takes priority over an expiry landing in the same cycle.
                    if (in_input_ack) begin
                        grant_valid_q <= in_input_valid;
                        grant_cpuid_q <= in_input_cpuid;
                        timed_out_q   <= 1'b0;
                        ctl_q         <= 1'b0;
                        state_q       <= REL;
                    end else if (timer_q == TO_LAST) begin
                        grant_valid_q <= 1'b0;
                        timed_out_q   <= 1'b1;
                        ctl_q         <= 1'b0;
                        to_cnt_q      <= sat_inc(to_cnt_q);
                        state_q       <= REL;
                    end else begin
                        timer_q <= timer_q + TO_W'(1);
                    end
                end
                REL: begin
                    if (!in_input_ack) begin
                        if (grant_valid_q) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= data_q;
                            out_cpuid_q <= grant_cpuid_q;
                            state_q     <= OUT;
                        end else begin
                            if (!timed_out_q) begin
                                drop_cnt_q <= sat_inc(drop_cnt_q);
                            end
                            state_q <= IDLE;
                        end
                    end
                end
                OUT: begin
                    if (in_desc_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ctl_q   <= 1'b0;
                end
            endcase
        end
    end

    assign out_desc_rdreq  = rdreq_q;
    assign out_input_ctl   = ctl_q;
    assign out_input_key   = key_q;
    assign out_desc_valid  = out_valid_q;
    assign out_desc_data   = out_data_q;
    assign out_desc_cpuid  = out_cpuid_q;
    assign out_drop_cnt    = drop_cnt_q;
    assign out_timeout_cnt = to_cnt_q;

endmodule
